// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed digit scanner for a common-anode style
// display. Steps through NUM_DIGITS digit slots of SCAN_DIV clocks each,
// presenting an active-low select, the digit code and a blank flag, with
// optional leading-zero blanking and per-digit blinking.
module display_scanner #(
  parameter int NUM_DIGITS = 8,
  parameter int DATA_W     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [NUM_DIGITS*DATA_W-1:0] data,
  input  logic [NUM_DIGITS-1:0]        blink_mask,
  input  logic                         blank_lz,
  output logic [NUM_DIGITS-1:0]        sel,
  output logic [DATA_W-1:0]            digit,
  output logic                         blank,
  output logic                         frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int FRM_W = $clog2(BLINK_DIV + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_DIV - 1);

  // Digit k is dark under leading-zero rules when every digit from the most
  // significant one down to k is zero; the rightmost digit always shows.
  function automatic logic lz_blank(input logic [NUM_DIGITS*DATA_W-1:0] d,
                                    input logic [IDX_W-1:0] k);
    logic nz;
    nz = 1'b0;
    for (int j = 1; j < NUM_DIGITS; j++) begin
      if ((j >= int'(k)) && (d[j*DATA_W +: DATA_W] != '0)) nz = 1'b1;
    end
    return (k != '0) && !nz;
  endfunction

  logic [PRE_W-1:0]      r_presc;
  logic [IDX_W-1:0]      r_idx;
  logic [FRM_W-1:0]      r_frm;
  logic                  r_phase;
  logic [NUM_DIGITS-1:0] r_sel;
  logic [DATA_W-1:0]     r_digit;
  logic                  r_blank;
  logic                  r_frame_done;

  logic                  w_tick;
  logic                  w_idx_wrap;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic                  w_frm_wrap;
  logic                  w_phase_nxt;
  logic                  w_blank_nxt;

  // Slot boundary detection and the values the scanner moves to on a tick.
  // The blink phase used for the new slot already includes a toggle caused
  // by this very wrap, so the first digit of a new blink period is correct.
  always_comb begin
    w_tick      = en & (r_presc == PRE_LAST);
    w_idx_wrap  = (r_idx == IDX_LAST);
    w_idx_nxt   = w_idx_wrap ? '0 : r_idx + IDX_W'(1);
    w_frm_wrap  = w_idx_wrap & (r_frm == FRM_LAST);
    w_phase_nxt = r_phase ^ w_frm_wrap;
    w_blank_nxt = (blank_lz & lz_blank(data, w_idx_nxt)) |
                  (w_phase_nxt & blink_mask[w_idx_nxt]);
  end

  // Prescaler, scan index, frame counter and blink phase; all hold while en=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_frm   <= '0;
      r_phase <= 1'b0;
    end else if (en) begin
      if (w_tick) begin
        r_presc <= '0;
        r_idx   <= w_idx_nxt;
        if (w_idx_wrap) begin
          r_frm   <= w_frm_wrap ? '0 : r_frm + FRM_W'(1);
          r_phase <= w_phase_nxt;
        end
      end else begin
        r_presc <= r_presc + PRE_W'(1);
      end
    end
  end

  // Registered display outputs, loaded only on a tick with the new slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel        <= ~NUM_DIGITS'(1);
      r_digit      <= '0;
      r_blank      <= 1'b1;
      r_frame_done <= 1'b0;
    end else if (w_tick) begin
      r_sel        <= ~(NUM_DIGITS'(1) << w_idx_nxt);
      r_digit      <= data[int'(w_idx_nxt)*DATA_W +: DATA_W];
      r_blank      <= w_blank_nxt;
      r_frame_done <= w_idx_wrap;
    end else begin
      r_frame_done <= 1'b0;
    end
  end

  assign sel        = r_sel;
  assign digit      = r_digit;
  assign blank      = r_blank;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: a cycle model pushes the expected output word
// for each clock into a queue; it is popped and compared after the edge.
module tb_display_scanner;

  localparam int ND = 8;
  localparam int DW = 4;
  localparam int SD = 4;
  localparam int BD = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           en = 1'b0;
  logic [31:0]    data = '0;
  logic [7:0]     blink_mask = '0;
  logic           blank_lz = 1'b0;
  logic [7:0]     sel;
  logic [3:0]     digit;
  logic           blank;
  logic           frame_done;

  int             total = 0;
  int             bad = 0;
  bit             chk_on = 1'b0;

  int             m_pre = 0;
  int             m_idx = 0;
  int             m_frm = 0;
  int             frames = 0;
  bit             m_ph = 1'b0;
  logic [13:0]    m_out = 14'h0;
  logic [13:0]    sb_q[$];

  always #5 clk = ~clk;

  display_scanner #(
    .NUM_DIGITS(ND), .DATA_W(DW), .SCAN_DIV(SD), .BLINK_DIV(BD)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .data(data),
    .blink_mask(blink_mask), .blank_lz(blank_lz),
    .sel(sel), .digit(digit), .blank(blank), .frame_done(frame_done)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Position of the most significant nonzero digit decides the blanking.
  function automatic bit lz_ref(input logic [31:0] d, input int k);
    int msd;
    msd = -1;
    for (int j = 0; j < ND; j++) if (d[j*DW +: DW] != 4'h0) msd = j;
    return (k > 0) && (k > msd);
  endfunction

  task automatic step();
    logic [13:0] e;
    @(posedge clk);
    if (reset) begin
      m_pre = 0; m_idx = 0; m_frm = 0; m_ph = 1'b0; frames = 0;
      m_out = {8'hFE, 4'h0, 1'b1, 1'b0};
    end else if (en) begin
      if (m_pre == SD - 1) begin
        m_pre = 0;
        m_idx = (m_idx + 1) % ND;
        if (m_idx == 0) begin
          frames++;
          m_frm++;
          if (m_frm == BD) begin m_frm = 0; m_ph = !m_ph; end
        end
        m_out = {~(8'h01 << m_idx), data[m_idx*DW +: DW],
                 (blank_lz && lz_ref(data, m_idx)) || (m_ph && blink_mask[m_idx]),
                 (m_idx == 0)};
      end else begin
        m_pre++;
        m_out[0] = 1'b0;
      end
    end else begin
      m_out[0] = 1'b0;
    end
    sb_q.push_back(m_out);
    #1;
    e = sb_q.pop_front();
    check_val("scan", 32'({sel, digit, blank, frame_done}), 32'(e));
  endtask

  task automatic wait_for(input int idx, input int pre, input int budget);
    int n;
    n = 0;
    while (!(m_idx == idx && m_pre == pre) && n < budget) begin
      step();
      n++;
    end
    check_val("wait_reached", 32'(m_idx == idx && m_pre == pre), 32'd1);
  endtask

  // Select must be one-hot-low on every cycle once reset has been applied.
  always @(negedge clk) begin
    if (chk_on) check_val("onehot", 32'($countones(~sel)), 32'd1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; en = 1'b0;
    step(); step();
    chk_on = 1'b1;
    check_val("rst_sel", 32'(sel), 32'hFE);
    check_val("rst_digit", 32'(digit), 32'h0);
    check_val("rst_blank", 32'(blank), 32'h1);
    check_val("rst_fd", 32'(frame_done), 32'h0);

    // Basic scan order and frame timing
    data = 32'h87654321; en = 1'b1; reset = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      step();
      if (c == 3) check_val("c3_sel", 32'(sel), 32'hFE);
      if (c == 4) begin
        check_val("c4_sel", 32'(sel), 32'hFD);
        check_val("c4_digit", 32'(digit), 32'h2);
        check_val("c4_blank", 32'(blank), 32'h0);
      end
      if (c == 8) begin
        check_val("c8_sel", 32'(sel), 32'hFB);
        check_val("c8_digit", 32'(digit), 32'h3);
      end
      if (c == 28) begin
        check_val("c28_sel", 32'(sel), 32'h7F);
        check_val("c28_digit", 32'(digit), 32'h8);
      end
      if (c == 31) check_val("c31_fd", 32'(frame_done), 32'h0);
      if (c == 32) begin
        check_val("c32_sel", 32'(sel), 32'hFE);
        check_val("c32_digit", 32'(digit), 32'h1);
        check_val("c32_fd", 32'(frame_done), 32'h1);
      end
    end

    // Leading-zero blanking
    blank_lz = 1'b1; data = 32'h00000305;
    for (int c = 1; c <= 32; c++) begin
      step();
      if (m_pre == 0) check_val("lz305", 32'(blank), 32'((8'hF8 >> m_idx) & 8'h01));
    end
    data = 32'h0;
    for (int c = 1; c <= 32; c++) begin
      step();
      if (m_pre == 0) check_val("lz0", 32'(blank), 32'((8'hFE >> m_idx) & 8'h01));
    end

    // Blinking on digit 0, two frames lit then two frames dark
    blank_lz = 1'b0; blink_mask = 8'h01; data = 32'h00000009;
    for (int c = 1; c <= 4 * 32; c++) begin
      step();
      if (frame_done === 1'b1)
        check_val("blink_d0", 32'(blank), 32'((frames / 2) % 2));
    end
    blink_mask = 8'h00;

    // Hold mid-slot with en low
    data = 32'h87654321;
    wait_for(3, 1, 64);
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check_val("hold_sel", 32'(sel), 32'hF7);
      check_val("hold_fd", 32'(frame_done), 32'h0);
    end
    en = 1'b1;
    n = 0;
    while (sel !== 8'hEF && n < 20) begin step(); n++; end
    check_val("resume_cycles", 32'(n), 32'd3);
    check_val("resume_digit", 32'(digit), 32'h5);

    // Reset coincident with a tick at index 5
    wait_for(5, SD - 1, 64);
    reset = 1'b1;
    step();
    check_val("rst5_sel", 32'(sel), 32'hFE);
    check_val("rst5_digit", 32'(digit), 32'h0);
    check_val("rst5_blank", 32'(blank), 32'h1);
    reset = 1'b0;
    n = 0;
    while (sel === 8'hFE && n < 20) begin step(); n++; end
    check_val("rst5_slot", 32'(n), 32'd4);

    // Data change mid-slot is ignored until the next tick
    data = 32'h11111111;
    wait_for(2, 0, 64);
    data = 32'h22222222;
    for (int c = 0; c < 3; c++) begin
      step();
      check_val("mid_digit", 32'(digit), 32'h1);
    end
    step();
    check_val("next_sel", 32'(sel), 32'hF7);
    check_val("next_digit", 32'(digit), 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
